// File: rtl/inta_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : inta_sequencer
//  Purpose  : CPU-facing interrupt-acknowledge sequencer of an 8259-style PIC.
//             Raises INT toward the CPU and follows the two INTA pulses of an
//             8086-mode acknowledge cycle. On the first pulse it freezes the
//             winning IR index, flags a spurious cycle when the request has
//             already gone, and (master, cascaded) drives the slave ID onto
//             the cascade lines. On the second pulse it places the vector
//             {T7..T3, idx} on the data bus when this PIC owns the cycle.
//             ack1/ack2 are one-cycle pulses for the in-service register.
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk                  in   system clock, rising edge
//    reset                in   synchronous, active-high
//    int_request          in   unmasked request above current in-service level
//    highest_priority_idx in   [2:0] winning IR index
//    vector_base          in   [4:0] ICW2 T7..T3
//    SNGL                 in   1 = single PIC, 0 = cascaded
//    SP                   in   1 = master, 0 = slave (ignored when SNGL=1)
//    AEOI                 in   automatic EOI mode (sequencing unaffected)
//    slave_map            in   [7:0] master ICW3, bit i = slave on IRi
//    slave_id             in   [2:0] slave ICW3, own cascade ID
//    inta_n               in   CPU acknowledge, active low, clk-synchronous
//    cas_in               in   [2:0] cascade lines seen by a slave
//    int_out              out  interrupt request to the CPU
//    ack1                 out  pulse: first INTA accepted
//    ack2                 out  pulse: second INTA accepted
//    serviced_idx         out  [2:0] IR index frozen at first INTA
//    spurious             out  current cycle is spurious
//    data_out             out  [7:0] vector byte
//    data_oe              out  data bus drive enable
//    cas_out              out  [2:0] cascade ID to slaves
//    cas_oe               out  cascade drive enable (master only)
// ============================================================================
module inta_sequencer (
    input  logic       clk,
    input  logic       reset,
    input  logic       int_request,
    input  logic [2:0] highest_priority_idx,
    input  logic [4:0] vector_base,
    input  logic       SNGL,
    input  logic       SP,
    input  logic       AEOI,
    input  logic [7:0] slave_map,
    input  logic [2:0] slave_id,
    input  logic       inta_n,
    input  logic [2:0] cas_in,
    output logic       int_out,
    output logic       ack1,
    output logic       ack2,
    output logic [2:0] serviced_idx,
    output logic       spurious,
    output logic [7:0] data_out,
    output logic       data_oe,
    output logic [2:0] cas_out,
    output logic       cas_oe
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_REQ    = 3'd1,
        ST_FIRST  = 3'd2,
        ST_WAIT2  = 3'd3,
        ST_SECOND = 3'd4
    } state_t;

    state_t     r_state;
    logic       r_inta_q;

    logic       w_inta_fall;
    logic       w_inta_rise;
    logic [2:0] w_latch_idx;
    logic       w_master_casc;
    logic       w_is_slave;
    logic       w_cas_sel;
    logic       w_owns_cycle;
    logic       w_unused_aeoi;

    assign w_inta_fall   = r_inta_q & ~inta_n;
    assign w_inta_rise   = ~r_inta_q & inta_n;

    // A request that vanished before INTA #1 is answered with IR7 (spurious).
    assign w_latch_idx   = int_request ? highest_priority_idx : 3'd7;

    assign w_master_casc = ~SNGL & SP;
    assign w_is_slave    = ~SNGL & ~SP;

    // Evaluated with the index being latched on this edge, so the cascade
    // lines come up together with ack1.
    assign w_cas_sel     = w_master_casc & slave_map[w_latch_idx];

    // Ownership of the vector byte, decided when INTA #2 falls.
    assign w_owns_cycle  = SNGL
                         | (w_master_casc & ~slave_map[serviced_idx])
                         | (w_is_slave & (cas_in == slave_id));

    // AEOI is consumed by the in-service register via ack2; the sequence
    // itself is identical in both modes.
    assign w_unused_aeoi = AEOI;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_inta_q     <= 1'b1;
            int_out      <= 1'b0;
            ack1         <= 1'b0;
            ack2         <= 1'b0;
            serviced_idx <= 3'd0;
            spurious     <= 1'b0;
            data_out     <= 8'd0;
            data_oe      <= 1'b0;
            cas_out      <= 3'd0;
            cas_oe       <= 1'b0;
        end else begin
            r_inta_q <= inta_n;
            ack1     <= 1'b0;
            ack2     <= 1'b0;

            case (r_state)
                ST_IDLE: begin
                    // INTA edges here are ignored; int_out follows the state
                    // register so it appears one cycle after entering REQ.
                    int_out <= 1'b0;
                    if (int_request) begin
                        r_state <= ST_REQ;
                    end
                end

                ST_REQ: begin
                    if (w_inta_fall) begin
                        r_state      <= ST_FIRST;
                        int_out      <= 1'b0;
                        serviced_idx <= w_latch_idx;
                        spurious     <= ~int_request;
                        ack1         <= int_request;
                        cas_oe       <= w_cas_sel;
                        cas_out      <= w_cas_sel ? w_latch_idx : 3'd0;
                    end else begin
                        // A request dropping here does not withdraw INT.
                        int_out <= 1'b1;
                    end
                end

                ST_FIRST: begin
                    if (w_inta_rise) begin
                        r_state <= ST_WAIT2;
                    end
                end

                ST_WAIT2: begin
                    if (w_inta_fall) begin
                        r_state  <= ST_SECOND;
                        ack2     <= ~spurious;
                        data_out <= {vector_base, serviced_idx};
                        data_oe  <= w_owns_cycle;
                    end
                end

                ST_SECOND: begin
                    if (w_inta_rise) begin
                        r_state  <= ST_IDLE;
                        data_oe  <= 1'b0;
                        data_out <= 8'd0;
                        cas_oe   <= 1'b0;
                        cas_out  <= 3'd0;
                        spurious <= 1'b0;
                    end
                end

                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_inta_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_inta_sequencer
//  Purpose  : Self-checking bench for inta_sequencer. Each scenario task runs
//             randomized acknowledge sequences and compares what it saw with
//             expectations derived from the acknowledge-protocol rules.
//  Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_inta_sequencer;

    logic       clk = 1'b0;
    logic       reset;
    logic       int_request;
    logic [2:0] highest_priority_idx;
    logic [4:0] vector_base;
    logic       SNGL;
    logic       SP;
    logic       AEOI;
    logic [7:0] slave_map;
    logic [2:0] slave_id;
    logic       inta_n;
    logic [2:0] cas_in;
    logic       int_out;
    logic       ack1;
    logic       ack2;
    logic [2:0] serviced_idx;
    logic       spurious;
    logic [7:0] data_out;
    logic       data_oe;
    logic [2:0] cas_out;
    logic       cas_oe;

    inta_sequencer dut (
        .clk                  (clk),
        .reset                (reset),
        .int_request          (int_request),
        .highest_priority_idx (highest_priority_idx),
        .vector_base          (vector_base),
        .SNGL                 (SNGL),
        .SP                   (SP),
        .AEOI                 (AEOI),
        .slave_map            (slave_map),
        .slave_id             (slave_id),
        .inta_n               (inta_n),
        .cas_in               (cas_in),
        .int_out              (int_out),
        .ack1                 (ack1),
        .ack2                 (ack2),
        .serviced_idx         (serviced_idx),
        .spurious             (spurious),
        .data_out             (data_out),
        .data_oe              (data_oe),
        .cas_out              (cas_out),
        .cas_oe               (cas_oe)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Observations collected by run_sequence
    int         obs_lat;
    int         obs_reint;
    int         obs_ack1_cnt;
    int         obs_ack2_cnt;
    logic       obs_int_after_fall;
    logic       obs_ack1_first;
    logic       obs_ack2_first;
    logic       obs_spur;
    logic [2:0] obs_idx;
    logic       obs_cas_oe;
    logic [2:0] obs_cas_out;
    logic       obs_cas_stable;
    logic       obs_doe_pre;
    logic       obs_doe;
    logic       obs_doe_stable;
    logic [7:0] obs_dout;
    logic       obs_end_doe;
    logic       obs_end_cas_oe;
    logic       obs_end_spur;

    // ---------------- reference model (protocol rules) ----------------
    function automatic logic [2:0] m_idx(input logic [2:0] idx, input bit drop);
        return drop ? 3'd7 : idx;
    endfunction

    function automatic logic m_cas(input logic [2:0] sidx);
        return !SNGL && SP && slave_map[sidx];
    endfunction

    function automatic logic m_owner(input logic [2:0] sidx);
        if (SNGL) return 1'b1;
        if (SP) return !slave_map[sidx];
        return cas_in == slave_id;
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        reset       = 1'b1;
        inta_n      = 1'b1;
        int_request = 1'b0;
        step();
        step();
        reset = 1'b0;
    endtask

    task automatic note(input bit in2);
        obs_ack1_cnt += int'(ack1);
        obs_ack2_cnt += int'(ack2);
        if (cas_oe !== obs_cas_oe || cas_out !== obs_cas_out) obs_cas_stable = 1'b0;
        if (!in2 && data_oe !== 1'b0) obs_doe_pre = 1'b1;
        if (in2 && data_oe !== obs_doe) obs_doe_stable = 1'b0;
    endtask

    // Full acknowledge sequence with random pulse widths.
    // drop: request removed one cycle before INTA #1; keep: request held after.
    // skip_raise: DUT is already in REQ with int_out high.
    task automatic run_sequence(input logic [2:0] idx, input bit drop,
                                input bit keep, input bit skip_raise);
        int l1, h, l2, w;
        l1 = $urandom_range(1, 3);
        h  = $urandom_range(1, 3);
        l2 = $urandom_range(1, 3);
        w  = $urandom_range(0, 2);
        AEOI = 1'($urandom_range(0, 1));
        highest_priority_idx = idx;
        int_request = 1'b1;
        obs_lat = -1;
        if (!skip_raise) begin
            for (int i = 1; i <= 10 && obs_lat < 0; i++) begin
                step();
                if (int_out === 1'b1) obs_lat = i;
            end
        end else begin
            obs_lat = 0;
        end
        repeat (w) step();
        if (drop) begin
            int_request = 1'b0;
            step();
        end
        // INTA #1
        inta_n = 1'b0;
        step();
        obs_int_after_fall = int_out;
        obs_ack1_first     = ack1;
        obs_idx            = serviced_idx;
        obs_spur           = spurious;
        obs_cas_oe         = cas_oe;
        obs_cas_out        = cas_out;
        obs_cas_stable     = 1'b1;
        obs_doe_pre        = data_oe;
        obs_ack1_cnt       = int'(ack1);
        obs_ack2_cnt       = int'(ack2);
        for (int i = 1; i < l1; i++) begin step(); note(1'b0); end
        inta_n = 1'b1;
        for (int i = 0; i < h; i++) begin step(); note(1'b0); end
        if (!keep) int_request = 1'b0;
        // INTA #2
        inta_n = 1'b0;
        step();
        obs_ack2_first = ack2;
        obs_doe        = data_oe;
        obs_dout       = data_out;
        obs_doe_stable = 1'b1;
        note(1'b1);
        for (int i = 1; i < l2; i++) begin step(); note(1'b1); end
        inta_n = 1'b1;
        step();
        obs_end_doe    = data_oe;
        obs_end_cas_oe = cas_oe;
        obs_end_spur   = spurious;
        obs_ack1_cnt  += int'(ack1);
        obs_ack2_cnt  += int'(ack2);
        obs_reint = -1;
        for (int i = 1; i <= 6; i++) begin
            step();
            if (int_out === 1'b1 && obs_reint < 0) obs_reint = i;
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        int seen;
        reset = 1'b1; int_request = 1'b1; inta_n = 1'b0;
        step();
        n_cmp++; if ({int_out, ack1, ack2, serviced_idx, spurious, data_out, data_oe, cas_out, cas_oe} !== 20'h0) begin n_err++; $display("FAIL reset.outputs got %h want 0", {int_out, ack1, ack2, serviced_idx, spurious, data_out, data_oe, cas_out, cas_oe}); end
        reset = 1'b0; int_request = 1'b0; inta_n = 1'b1;
        step();
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            inta_n = i[0];
            step();
            if (int_out !== 1'b0 || ack1 !== 1'b0 || ack2 !== 1'b0 || data_oe !== 1'b0) seen++;
        end
        n_cmp++; if (seen !== 0) begin n_err++; $display("FAIL reset.idle_inta_ignored got %0d active cycles want 0", seen); end
    endtask

    task automatic test_single();
        logic [2:0] idx;
        logic [7:0] vexp;
        for (int k = 0; k < 4; k++) begin
            apply_reset();
            SNGL = 1'b1; SP = 1'($urandom_range(0, 1)); slave_map = 8'($urandom);
            cas_in = 3'($urandom); slave_id = 3'($urandom);
            if (k == 0) begin
                vector_base = 5'b01000; idx = 3'd3; vexp = 8'h43;
            end else begin
                vector_base = 5'($urandom); idx = 3'($urandom); vexp = {vector_base, idx};
            end
            run_sequence(idx, 1'b0, 1'b0, 1'b0);
            n_cmp++; if (obs_lat !== 2) begin n_err++; $display("FAIL single.int_latency got %0d want 2", obs_lat); end
            n_cmp++; if (obs_int_after_fall !== 1'b0) begin n_err++; $display("FAIL single.int_drop got %b want 0", obs_int_after_fall); end
            n_cmp++; if (obs_ack1_first !== 1'b1 || obs_ack1_cnt !== 1) begin n_err++; $display("FAIL single.ack1 got first=%b cnt=%0d want 1/1", obs_ack1_first, obs_ack1_cnt); end
            n_cmp++; if (obs_ack2_first !== 1'b1 || obs_ack2_cnt !== 1) begin n_err++; $display("FAIL single.ack2 got first=%b cnt=%0d want 1/1", obs_ack2_first, obs_ack2_cnt); end
            n_cmp++; if (obs_idx !== m_idx(idx, 1'b0)) begin n_err++; $display("FAIL single.idx got %0d want %0d", obs_idx, idx); end
            n_cmp++; if (obs_doe_pre !== 1'b0 || obs_doe !== 1'b1 || obs_doe_stable !== 1'b1) begin n_err++; $display("FAIL single.data_oe got pre=%b oe=%b stable=%b want 0/1/1", obs_doe_pre, obs_doe, obs_doe_stable); end
            n_cmp++; if (obs_dout !== vexp) begin n_err++; $display("FAIL single.vector got %h want %h", obs_dout, vexp); end
            n_cmp++; if (obs_end_doe !== 1'b0 || obs_cas_oe !== 1'b0) begin n_err++; $display("FAIL single.release got end_oe=%b cas_oe=%b want 0/0", obs_end_doe, obs_cas_oe); end
            n_cmp++; if (obs_reint !== -1) begin n_err++; $display("FAIL single.no_reint got %0d want -1", obs_reint); end
        end
    endtask

    task automatic test_spurious();
        logic [2:0] idx;
        for (int k = 0; k < 2; k++) begin
            apply_reset();
            SNGL = 1'b1; SP = 1'b1; slave_map = 8'h00;
            vector_base = 5'($urandom); idx = 3'($urandom_range(0, 6));
            run_sequence(idx, 1'b1, 1'b0, 1'b0);
            n_cmp++; if (obs_idx !== m_idx(idx, 1'b1) || obs_spur !== 1'b1) begin n_err++; $display("FAIL spurious.latch got idx=%0d spur=%b want 7/1", obs_idx, obs_spur); end
            n_cmp++; if (obs_ack1_cnt !== 0 || obs_ack2_cnt !== 0) begin n_err++; $display("FAIL spurious.no_acks got ack1=%0d ack2=%0d want 0/0", obs_ack1_cnt, obs_ack2_cnt); end
            n_cmp++; if (obs_dout !== {vector_base, 3'b111} || obs_doe !== 1'b1) begin n_err++; $display("FAIL spurious.vector got %h oe=%b want %h/1", obs_dout, obs_doe, {vector_base, 3'b111}); end
            n_cmp++; if (obs_end_spur !== 1'b0 || obs_int_after_fall !== 1'b0) begin n_err++; $display("FAIL spurious.release got spur=%b int=%b want 0/0", obs_end_spur, obs_int_after_fall); end
        end
    endtask

    task automatic test_master_cascade();
        logic [2:0] idx;
        logic       ecas;
        for (int k = 0; k < 4; k++) begin
            apply_reset();
            SNGL = 1'b0; SP = 1'b1; vector_base = 5'($urandom);
            if (k == 0) begin slave_map = 8'h04; idx = 3'd2; end
            else begin slave_map = 8'($urandom); idx = 3'($urandom); end
            ecas = m_cas(idx);
            run_sequence(idx, 1'b0, 1'b0, 1'b0);
            n_cmp++; if (obs_cas_oe !== ecas || (ecas && obs_cas_out !== idx)) begin n_err++; $display("FAIL master.cas got oe=%b out=%0d want %b/%0d", obs_cas_oe, obs_cas_out, ecas, idx); end
            n_cmp++; if (obs_cas_stable !== 1'b1 || obs_end_cas_oe !== 1'b0) begin n_err++; $display("FAIL master.cas_hold got stable=%b end=%b want 1/0", obs_cas_stable, obs_end_cas_oe); end
            n_cmp++; if (obs_doe !== m_owner(idx)) begin n_err++; $display("FAIL master.data_oe got %b want %b", obs_doe, m_owner(idx)); end
            n_cmp++; if (obs_ack1_first !== 1'b1 || obs_ack2_first !== 1'b1) begin n_err++; $display("FAIL master.acks got %b%b want 11", obs_ack1_first, obs_ack2_first); end
        end
    endtask

    task automatic test_slave();
        logic [2:0] idx;
        logic       eown;
        for (int k = 0; k < 4; k++) begin
            apply_reset();
            SNGL = 1'b0; SP = 1'b0; slave_map = 8'($urandom);
            vector_base = 5'($urandom); idx = 3'($urandom);
            if (k < 2) begin
                slave_id = 3'd2; cas_in = (k == 0) ? 3'd2 : 3'd5;
            end else begin
                slave_id = 3'($urandom);
                cas_in = ($urandom_range(0, 1) == 1) ? slave_id : 3'($urandom);
            end
            eown = m_owner(idx);
            run_sequence(idx, 1'b0, 1'b0, 1'b0);
            n_cmp++; if (obs_doe !== eown) begin n_err++; $display("FAIL slave.data_oe got %b want %b", obs_doe, eown); end
            n_cmp++; if (obs_ack2_first !== 1'b1 || obs_ack2_cnt !== 1) begin n_err++; $display("FAIL slave.ack2 got first=%b cnt=%0d want 1/1", obs_ack2_first, obs_ack2_cnt); end
            n_cmp++; if (obs_cas_oe !== 1'b0) begin n_err++; $display("FAIL slave.no_cas got %b want 0", obs_cas_oe); end
            n_cmp++; if (eown && obs_dout !== {vector_base, idx}) begin n_err++; $display("FAIL slave.vector got %h want %h", obs_dout, {vector_base, idx}); end
        end
    endtask

    task automatic test_reset_in_wait2();
        int seen;
        int lat;
        apply_reset();
        SNGL = 1'b0; SP = 1'b1; slave_map = 8'hFF;
        highest_priority_idx = 3'($urandom); int_request = 1'b1;
        lat = -1;
        for (int i = 1; i <= 10 && lat < 0; i++) begin step(); if (int_out === 1'b1) lat = i; end
        n_cmp++; if (lat !== 2) begin n_err++; $display("FAIL rstw2.int_latency got %0d want 2", lat); end
        inta_n = 1'b0; step();
        inta_n = 1'b1; step();
        n_cmp++; if (cas_oe !== 1'b1) begin n_err++; $display("FAIL rstw2.cas_before got %b want 1", cas_oe); end
        reset = 1'b1; int_request = 1'b0;
        step();
        n_cmp++; if ({int_out, ack1, ack2, serviced_idx, spurious, data_out, data_oe, cas_out, cas_oe} !== 20'h0) begin n_err++; $display("FAIL rstw2.outputs got %h want 0", {int_out, ack1, ack2, serviced_idx, spurious, data_out, data_oe, cas_out, cas_oe}); end
        reset = 1'b0;
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            inta_n = (i == 0 || i == 1 || i == 3) ? 1'b0 : 1'b1;
            step();
            if (ack1 !== 1'b0 || ack2 !== 1'b0 || int_out !== 1'b0 || data_oe !== 1'b0 || cas_oe !== 1'b0) seen++;
        end
        n_cmp++; if (seen !== 0) begin n_err++; $display("FAIL rstw2.no_pulses got %0d active cycles want 0", seen); end
    endtask

    task automatic test_back_to_back();
        logic [2:0] a, b;
        apply_reset();
        SNGL = 1'b1; SP = 1'b1; slave_map = 8'h00; vector_base = 5'($urandom);
        a = 3'($urandom);
        b = a ^ 3'($urandom_range(1, 7));
        run_sequence(a, 1'b0, 1'b1, 1'b0);
        n_cmp++; if (obs_idx !== a) begin n_err++; $display("FAIL b2b.first_idx got %0d want %0d", obs_idx, a); end
        n_cmp++; if (obs_reint !== 2) begin n_err++; $display("FAIL b2b.reint got %0d want 2", obs_reint); end
        run_sequence(b, 1'b0, 1'b0, 1'b1);
        n_cmp++; if (obs_idx !== b || obs_ack1_first !== 1'b1) begin n_err++; $display("FAIL b2b.second_idx got %0d ack1=%b want %0d/1", obs_idx, obs_ack1_first, b); end
        n_cmp++; if (obs_dout !== {vector_base, b} || obs_doe !== 1'b1) begin n_err++; $display("FAIL b2b.second_vector got %h oe=%b want %h/1", obs_dout, obs_doe, {vector_base, b}); end
    endtask

    initial begin
        reset = 1'b1; int_request = 1'b0; highest_priority_idx = 3'd0;
        vector_base = 5'd0; SNGL = 1'b1; SP = 1'b1; AEOI = 1'b0;
        slave_map = 8'h00; slave_id = 3'd0; inta_n = 1'b1; cas_in = 3'd0;
        test_reset();
        test_single();
        test_spurious();
        test_master_cascade();
        test_slave();
        test_reset_in_wait2();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
